// File: rtl/cfu_initiator_pkg.sv
// Shared constants and helpers for the CFU initiator slice.
// Status encoding, default widths and parameter sanity helpers.
package cfu_initiator_pkg;

  localparam logic CFU_STATUS_OK  = 1'b1;
  localparam logic CFU_STATUS_ERR = 1'b0;

  localparam int CFU_FUNC_ID_W = 10;
  localparam int CFU_DATA_W    = 32;
  localparam int CFU_RD_W      = 5;
  localparam int CFU_TMR_W     = 16;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/cfu_tag_fifo.sv
// In-order tag FIFO holding destination registers of outstanding requests.
// Ports: push/din write, pop advances head, count = occupancy.
module cfu_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/cfu_initiator.sv
// CPU-side CFU initiator: issue -> req register, resp -> wb register,
// in-order tag FIFO of rd. Optional watchdog under CFU_TIMEOUT_EN.
// Ports: issue_* (core in), req_* (to CFU), resp_* (from CFU),
// wb_* (to core), outstanding count, sticky unexpected_resp.
module cfu_initiator
  import cfu_initiator_pkg::*;
#(
  parameter int FUNC_ID_W   = CFU_FUNC_ID_W,
  parameter int DATA_W      = CFU_DATA_W,
  parameter int N_INPUTS    = 2,
  parameter int RD_W        = CFU_RD_W,
  parameter int MAX_OUT     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [FUNC_ID_W-1:0]         issue_function_id,
  input  logic [N_INPUTS*DATA_W-1:0]   issue_data,
  input  logic [RD_W-1:0]              issue_rd,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic [FUNC_ID_W-1:0]         req_function_id,
  output logic [N_INPUTS*DATA_W-1:0]   req_data,
  input  logic                         resp_valid,
  output logic                         resp_ready,
  input  logic [DATA_W-1:0]            resp_data,
  input  logic                         resp_ok,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [RD_W-1:0]              wb_rd,
  output logic [DATA_W-1:0]            wb_data,
  output logic                         wb_err,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         unexpected_resp
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic            issue_fire;
  logic            resp_fire;
  logic            resp_take;
  logic            unexp_fire;
  logic            pop;
  logic            empty;
  logic            tmo_fire;
  logic [RD_W-1:0] head;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     busy;

  if (!is_pow2(MAX_OUT) || MAX_OUT < 2 || TIMEOUT_CYC < 1 ||
      TIMEOUT_CYC >= (1 << CFU_TMR_W)) begin : g_bad_cfg
    $error("cfu_initiator: illegal MAX_OUT or TIMEOUT_CYC");
  end

  // Dropped (timed-out) requests still own a CFU slot until
  // their late response drains, so they count against capacity.
  assign busy        = {1'b0, outstanding} + {1'b0, drop_cnt};
  assign issue_ready = (!req_valid || req_ready) &&
                       (busy < (CW+1)'(MAX_OUT));
  assign issue_fire  = issue_valid && issue_ready;

  assign resp_ready = !wb_valid || wb_ready;
  assign resp_fire  = resp_valid && resp_ready;
  assign empty      = (outstanding == '0);
  assign resp_take  = resp_fire && !empty && (drop_cnt == '0);
  assign unexp_fire = resp_fire && empty && (drop_cnt == '0);
  assign pop        = resp_take || tmo_fire;

  cfu_tag_fifo #(
    .DEPTH (MAX_OUT),
    .W     (RD_W)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (issue_fire),
    .din   (issue_rd),
    .pop   (pop),
    .head  (head),
    .count (outstanding)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid       <= 1'b0;
      req_function_id <= '0;
      req_data        <= '0;
    end else if (issue_fire) begin
      req_valid       <= 1'b1;
      req_function_id <= issue_function_id;
      req_data        <= issue_data;
    end else if (req_ready) begin
      req_valid <= 1'b0;
    end
  end

  // pop only happens when the wb register is free (resp_ready).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_err   <= 1'b0;
    end else if (pop) begin
      wb_valid <= 1'b1;
      wb_rd    <= head;
      wb_data  <= tmo_fire ? '0 : resp_data;
      wb_err   <= tmo_fire || (resp_ok != CFU_STATUS_OK);
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) unexpected_resp <= 1'b0;
    else if (unexp_fire) unexpected_resp <= 1'b1;
  end

`ifdef CFU_TIMEOUT_EN
  logic [CFU_TMR_W-1:0] timer;
  logic                 tmo_hit;

  // Timer saturates at the limit while the wb register is busy;
  // a response arriving in the same cycle always wins.
  assign tmo_hit  = (timer >= CFU_TMR_W'(TIMEOUT_CYC));
  assign tmo_fire = tmo_hit && !empty && !resp_fire && resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      drop_cnt <= '0;
    end else begin
      if (resp_fire || empty || tmo_fire) timer <= '0;
      else if (!tmo_hit) timer <= timer + 1'b1;
      if (tmo_fire) drop_cnt <= drop_cnt + 1'b1;
      else if (resp_fire && drop_cnt != '0)
        drop_cnt <= drop_cnt - 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign drop_cnt = '0;
`endif

endmodule
